// File: rtl/acq_buf_if.sv
// Stream-in and system-bus signals of the capture buffer, grouped for port binding.
interface acq_buf_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned CWM = 14
);
    logic [DW-1:0]  sti_tdata;
    logic           sti_tvalid;
    logic           sti_tready;
    logic           bus_wen;
    logic           bus_ren;
    logic [CWM+1:0] bus_addr;
    logic [31:0]    bus_wdata;
    logic [31:0]    bus_rdata;
    logic           bus_ack;
    logic           bus_err;

    // Producer of samples and issuer of bus accesses.
    modport master (
        output sti_tdata, sti_tvalid,
        input  sti_tready,
        output bus_wen, bus_ren, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    // The capture buffer itself.
    modport slave (
        input  sti_tdata, sti_tvalid,
        output sti_tready,
        input  bus_wen, bus_ren, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/acq_buf.sv
// Stream-capture buffer: circular sample RAM fed by an AXI4-stream, pre/trigger/post
// capture FSM, and CPU readback of the RAM over the system bus.
module acq_buf #(
    parameter int unsigned TN  = 1,
    parameter int unsigned DW  = 16,
    parameter int unsigned CWM = 14,
    parameter int unsigned CW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    acq_buf_if.slave       sif,
    input  logic           ctl_rst,
    input  logic           ctl_acq,
    input  logic [TN-1:0]  trg_i,
    input  logic [TN-1:0]  cfg_trg,
    input  logic [CW-1:0]  cfg_pre,
    input  logic [CW-1:0]  cfg_pst,
    output logic           sts_run,
    output logic [CW-1:0]  sts_pre,
    output logic [CW-1:0]  sts_pst,
    output logic [CWM-1:0] sts_ptr,
    output logic [CWM-1:0] sts_tpt,
    output logic           trg_o,
    output logic           irq_trg,
    output logic           irq_stp
);
    localparam int unsigned Depth = 2 ** CWM;

    typedef enum logic [1:0] {StIdle, StPre, StTrg, StPst} state_e;

    state_e         state_q, state_d;
    logic           tready_q;
    logic [CW-1:0]  pre_q, pst_q, pre_nxt;
    logic [CWM-1:0] ptr_q, tpt_q;
    logic           trg_o_q;
    logic           ack_q;
    logic [31:0]    rdata_q;
    logic [DW-1:0]  mem_q [Depth];

    logic beat, trg;
    logic wr_en, pre_inc, pst_inc, tpt_ld, cnt_clr;

    assign beat = sif.sti_tvalid & tready_q;
    assign trg  = |(trg_i & cfg_trg);

    // Saturating pre-trigger count including this cycle's beat; PRE exits on it so the
    // state flips on the same edge that sts_pre reaches cfg_pre.
    always_comb begin
        pre_nxt = pre_q;
        if (beat && (pre_q != '1)) begin
            pre_nxt = pre_q + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ctl_rst overrides every transition.
    always_comb begin
        state_d = state_q;
        if (ctl_rst) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (ctl_acq) state_d = StPre;
                StPre:   if (pre_nxt >= cfg_pre) state_d = StTrg;
                StTrg:   if (trg) state_d = StPst;
                StPst:   if (pst_q == cfg_pst) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: datapath strobes and interrupt pulses.
    always_comb begin
        wr_en   = 1'b0;
        pre_inc = 1'b0;
        pst_inc = 1'b0;
        tpt_ld  = 1'b0;
        cnt_clr = 1'b0;
        irq_trg = 1'b0;
        irq_stp = 1'b0;
        if (!ctl_rst) begin
            case (state_q)
                StIdle: cnt_clr = ctl_acq;
                StPre: begin
                    wr_en   = beat;
                    pre_inc = beat;
                end
                StTrg: begin
                    // A beat in the trigger cycle still counts as pre-trigger.
                    wr_en   = beat;
                    pre_inc = beat;
                    tpt_ld  = trg;
                    irq_trg = trg;
                end
                StPst: begin
                    if (pst_q == cfg_pst) begin
                        irq_stp = 1'b1;
                    end else begin
                        wr_en   = beat;
                        pst_inc = beat;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counters, write pointer, trigger address and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tready_q <= 1'b0;
            pre_q    <= '0;
            pst_q    <= '0;
            ptr_q    <= '0;
            tpt_q    <= '0;
            trg_o_q  <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            trg_o_q  <= irq_trg;
            if (ctl_rst) begin
                pre_q <= '0;
                pst_q <= '0;
                ptr_q <= '0;
                tpt_q <= '0;
            end else begin
                if (cnt_clr) begin
                    pre_q <= '0;
                    pst_q <= '0;
                end
                if (pre_inc) pre_q <= pre_nxt;
                if (pst_inc) pst_q <= pst_q + CW'(1);
                if (wr_en)   ptr_q <= ptr_q + CWM'(1);
                if (tpt_ld)  tpt_q <= ptr_q;
            end
        end
    end

    // Stream write port of the sample RAM; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= sif.sti_tdata;
        end
    end

    // Bus read port: one-cycle latency, old data on a same-address write; writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= sif.bus_wen | sif.bus_ren;
            if (sif.bus_ren) begin
                rdata_q <= 32'(mem_q[sif.bus_addr[CWM+1:2]]);
            end
        end
    end

    logic unused_bus;
    assign unused_bus = ^{sif.bus_wdata, sif.bus_addr[1:0]};

    assign sif.sti_tready = tready_q;
    assign sif.bus_rdata  = rdata_q;
    assign sif.bus_ack    = ack_q;
    assign sif.bus_err    = 1'b0;

    assign sts_run = (state_q != StIdle);
    assign sts_pre = pre_q;
    assign sts_pst = pst_q;
    assign sts_ptr = ptr_q;
    assign sts_tpt = tpt_q;
    assign trg_o   = trg_o_q;
endmodule
